// File: rtl/axi_lite_pkg.sv
// Shared types and helpers for the AXI4-Lite register bank.
package axi_lite_pkg;

  // AXI response codes used by this slave.
  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  // Widest supported data bus and its strobe width. Narrower buses are
  // zero-extended into the helper and truncated on the way out.
  localparam int DATA_WIDTH_MAX = 64;
  localparam int STRB_W         = DATA_WIDTH_MAX / 8;

  // Replace every byte of old_word whose strobe bit is set with the
  // matching byte of new_word; all other bytes are kept.
  function automatic logic [DATA_WIDTH_MAX-1:0] strb_merge(
    input logic [DATA_WIDTH_MAX-1:0] old_word,
    input logic [DATA_WIDTH_MAX-1:0] new_word,
    input logic [STRB_W-1:0]         strb
  );
    logic [DATA_WIDTH_MAX-1:0] merged;
    merged = old_word;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi_lite_regbank.sv
// Parametrised AXI4-Lite slave register bank with byte-lane writes,
// read-only status mapping, SLVERR decode and per-register write pulses.
module axi_lite_regbank
  import axi_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 32,   // 32 or 64
  parameter int                    NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  // write address
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  // write data
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  // write response
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  // read address
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  // read data
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  // block-side control/status
  output logic [NUM_REGS*DATA_WIDTH-1:0] REG_Q,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] HW_STATUS,
  output logic [NUM_REGS-1:0]            WR_PULSE
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int LANES = DATA_WIDTH / 8;

  logic                  ready_en;
  logic                  aw_held;
  logic                  w_held;
  logic [IDX_W-1:0]      aw_idx;
  logic [DATA_WIDTH-1:0] w_data;
  logic [LANES-1:0]      w_strb;
  logic                  commit;
  logic                  wr_hit;
  logic                  wr_ro;
  logic                  wr_ok;
  logic [NUM_REGS-1:0]   wr_sel;
  logic [IDX_W-1:0]      ar_idx;
  logic                  rd_hit;
  logic [DATA_WIDTH-1:0] rd_word;

  // Byte offset within a word carries no meaning for this slave.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{AWADDR[1:0], ARADDR[1:0]};

  assign ar_idx = ARADDR[ADDR_WIDTH-1:2];

  // Ready outputs come only from registered state, never from the VALIDs.
  assign AWREADY = ready_en && !aw_held && !BVALID;
  assign WREADY  = ready_en && !w_held  && !BVALID;
  assign ARREADY = ready_en && !RVALID;

  // A write commits once both halves are held and no response is pending.
  assign commit = aw_held && w_held && !BVALID;

  // Keep every ready low until the first edge after reset is released.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values of its neighbours.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // Capture the write address and hold it until the commit.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_held <= 1'b0;
      aw_idx  <= '0;
    end else if (AWVALID && AWREADY) begin
      aw_held <= 1'b1;
      aw_idx  <= AWADDR[ADDR_WIDTH-1:2];
    end else if (commit) begin
      aw_held <= 1'b0;
    end
  end

  // Capture the write data and strobes and hold them until the commit.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_held <= 1'b0;
      w_data <= '0;
      w_strb <= '0;
    end else if (WVALID && WREADY) begin
      w_held <= 1'b1;
      w_data <= WDATA;
      w_strb <= WSTRB;
    end else if (commit) begin
      w_held <= 1'b0;
    end
  end

  // Decode the held write address into a register select and a legality flag.
  // NOTE: every output of a combinational block gets a default first so no
  // path through the loop can leave a value unassigned and infer a latch.
  always_comb begin
    wr_hit = 1'b0;
    wr_ro  = 1'b0;
    wr_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (aw_idx == IDX_W'(i)) begin
        wr_hit    = 1'b1;
        wr_ro     = RO_MASK[i];
        wr_sel[i] = !RO_MASK[i];
      end
    end
  end

  assign wr_ok = wr_hit && !wr_ro;

  // Raise BVALID on the commit and hold it with its response until accepted.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      BVALID <= 1'b0;
      BRESP  <= OKAY;
    end else if (commit) begin
      BVALID <= 1'b1;
      BRESP  <= wr_ok ? OKAY : SLVERR;
    end else if (BVALID && BREADY) begin
      BVALID <= 1'b0;
    end
  end

  // One-cycle strobe for the register written on the commit edge,
  // including writes whose strobes are all clear.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) WR_PULSE <= '0;
    else        WR_PULSE <= commit ? wr_sel : '0;
  end

  // Register storage: RW slots hold flops, RO slots drive zero and keep none.
  // NOTE: the register array is reset because its contents are visible on
  // REG_Q straight out of reset; RO slots have no storage to reset at all.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (RO_MASK[i]) begin : g_ro
      assign REG_Q[i*DATA_WIDTH +: DATA_WIDTH] = '0;
    end else begin : g_rw
      logic [DATA_WIDTH-1:0] q;

      // Byte-merge the held write into this register on its commit.
      always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
          q <= RESET_VAL;
        end else if (commit && wr_sel[i]) begin
          q <= DATA_WIDTH'(strb_merge(DATA_WIDTH_MAX'(q),
                                      DATA_WIDTH_MAX'(w_data),
                                      STRB_W'(w_strb)));
        end
      end

      assign REG_Q[i*DATA_WIDTH +: DATA_WIDTH] = q;
    end
  end

  // Select the read source: RO slots show live status, RW slots their flops.
  always_comb begin
    rd_hit  = 1'b0;
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDX_W'(i)) begin
        rd_hit  = 1'b1;
        rd_word = RO_MASK[i] ? HW_STATUS[i*DATA_WIDTH +: DATA_WIDTH]
                             : REG_Q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Load the read response on the AR handshake; hold it until accepted.
  // A commit on the same edge is invisible here, so the old value is returned.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      RVALID <= 1'b0;
      RDATA  <= '0;
      RRESP  <= OKAY;
    end else if (ARVALID && ARREADY) begin
      RVALID <= 1'b1;
      RDATA  <= rd_hit ? rd_word : '0;
      RRESP  <= rd_hit ? OKAY : SLVERR;
    end else if (RVALID && RREADY) begin
      RVALID <= 1'b0;
    end
  end

endmodule
